// File: rtl/conv_column_feeder_pkg.sv
// Shared constants and FSM encoding for the conv_2d column feeder.
package conv_column_feeder_pkg;

    // Default pixel / coefficient width
    localparam int CONV_DATA_W = 8;

    // Number of kernel taps in a 3x3 window
    localparam int KNL_TAPS = 9;

    // Slice index of kN inside the packed kernel word (kN at index N-1)
    localparam int K1_IDX = 0;
    localparam int K2_IDX = 1;
    localparam int K3_IDX = 2;
    localparam int K4_IDX = 3;
    localparam int K5_IDX = 4;
    localparam int K6_IDX = 5;
    localparam int K7_IDX = 6;
    localparam int K8_IDX = 7;
    localparam int K9_IDX = 8;

    // Feeder sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KNL0   = 3'd1,
        ST_KNL1   = 3'd2,
        ST_KNL2   = 3'd3,
        ST_STREAM = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/conv_column_feeder_if.sv
// Pixel-in / window-column-out bundle between a pixel source, the feeder and conv_2d.
interface conv_column_feeder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_pixel;
    logic              i_valid;
    logic              o_ready;
    logic              o_load_knl;
    logic [DATA_W-1:0] o_data1;
    logic [DATA_W-1:0] o_data2;
    logic [DATA_W-1:0] o_data3;
    logic              o_strobe;
    logic              o_data_valid;

    // Source / observer side
    modport master (
        output i_pixel, i_valid,
        input  o_ready, o_load_knl, o_data1, o_data2, o_data3, o_strobe, o_data_valid
    );

    // Feeder side
    modport slave (
        input  i_pixel, i_valid,
        output o_ready, o_load_knl, o_data1, o_data2, o_data3, o_strobe, o_data_valid
    );
endinterface

// File: rtl/conv_column_feeder_column_buffer.sv
// Two column stores indexed by row: buf_b holds column c-1, buf_a holds column c-2.
// A write at a row shifts that row's column-(c-1) pixel into the c-2 store.
module conv_column_feeder_column_buffer #(
    parameter int DEPTH  = 12,
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    logic [DATA_W-1:0] buf_a_r [DEPTH];
    logic [DATA_W-1:0] buf_b_r [DEPTH];

    // Read port returns the pre-write contents of the addressed row
    assign rd_a = buf_a_r[addr];
    assign rd_b = buf_b_r[addr];

    // Shift the addressed row by one column on every accepted pixel
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_b_r[addr] <= wr_data;
            buf_a_r[addr] <= buf_b_r[addr];
        end
    end

endmodule

// File: rtl/conv_column_feeder.sv
// Feeds conv_2d: loads the 3x3 kernel as three triples, then streams three
// adjacent columns (c-2, c-1, c) of a column-major padded frame per beat.
module conv_column_feeder
    import conv_column_feeder_pkg::*;
#(
    parameter int IMAGE_HEIGHT    = 12,
    parameter int IMAGE_WIDTH     = 3,
    parameter int DATA_W          = CONV_DATA_W,
    parameter int VALID_ROW_START = 3
) (
    input  logic                         clk,
    input  logic                         i_nrst,
    input  logic                         i_start,
    input  logic [KNL_TAPS*DATA_W-1:0]   i_kernel,
    conv_column_feeder_if.slave          px,
    output logic                         o_busy,
    output logic                         o_frame_done
);

    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    localparam logic [RW-1:0] ROW_LAST   = RW'(IMAGE_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_VALID  = RW'(VALID_ROW_START);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] COL_BEAT0  = CW'(2);

    // Only k1..k6 need holding; k7..k9 go out on the start cycle itself
    localparam int KHOLD_W = K7_IDX * DATA_W;

    state_t             state_r;
    logic [RW-1:0]      row_r;
    logic [CW-1:0]      col_r;
    logic [KHOLD_W-1:0] kernel_r;

    logic               accept_s;
    logic [DATA_W-1:0]  col_a_s;
    logic [DATA_W-1:0]  col_b_s;

    // A pixel is taken only while streaming with both sides ready
    assign accept_s = (state_r == ST_STREAM) && px.i_valid && px.o_ready;

    conv_column_feeder_column_buffer #(
        .DEPTH  (IMAGE_HEIGHT),
        .DATA_W (DATA_W),
        .AW     (RW)
    ) u_column_buffer (
        .clk     (clk),
        .wr_en   (accept_s),
        .addr    (row_r),
        .wr_data (px.i_pixel),
        .rd_a    (col_a_s),
        .rd_b    (col_b_s)
    );

    // Sequencer, row/column counters and all registered outputs
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_r         <= ST_IDLE;
            row_r           <= '0;
            col_r           <= '0;
            kernel_r        <= '0;
            px.o_ready      <= 1'b0;
            px.o_load_knl   <= 1'b0;
            px.o_data1      <= '0;
            px.o_data2      <= '0;
            px.o_data3      <= '0;
            px.o_strobe     <= 1'b0;
            px.o_data_valid <= 1'b0;
            o_busy          <= 1'b0;
            o_frame_done    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    px.o_ready      <= 1'b0;
                    px.o_strobe     <= 1'b0;
                    px.o_data_valid <= 1'b0;
                    o_frame_done    <= 1'b0;
                    if (i_start) begin
                        kernel_r      <= i_kernel[KHOLD_W-1:0];
                        px.o_load_knl <= 1'b1;
                        px.o_data1    <= i_kernel[K9_IDX*DATA_W +: DATA_W];
                        px.o_data2    <= i_kernel[K8_IDX*DATA_W +: DATA_W];
                        px.o_data3    <= i_kernel[K7_IDX*DATA_W +: DATA_W];
                        o_busy        <= 1'b1;
                        row_r         <= '0;
                        col_r         <= '0;
                        state_r       <= ST_KNL0;
                    end else begin
                        px.o_load_knl <= 1'b0;
                        o_busy        <= 1'b0;
                    end
                end
                ST_KNL0: begin
                    px.o_data1 <= kernel_r[K6_IDX*DATA_W +: DATA_W];
                    px.o_data2 <= kernel_r[K5_IDX*DATA_W +: DATA_W];
                    px.o_data3 <= kernel_r[K4_IDX*DATA_W +: DATA_W];
                    state_r    <= ST_KNL1;
                end
                ST_KNL1: begin
                    px.o_data1 <= kernel_r[K3_IDX*DATA_W +: DATA_W];
                    px.o_data2 <= kernel_r[K2_IDX*DATA_W +: DATA_W];
                    px.o_data3 <= kernel_r[K1_IDX*DATA_W +: DATA_W];
                    state_r    <= ST_KNL2;
                end
                ST_KNL2: begin
                    px.o_load_knl <= 1'b0;
                    px.o_ready    <= 1'b1;
                    state_r       <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (accept_s) begin
                        // Columns 0 and 1 only prime the buffers
                        if (col_r >= COL_BEAT0) begin
                            px.o_data1      <= col_a_s;
                            px.o_data2      <= col_b_s;
                            px.o_data3      <= px.i_pixel;
                            px.o_strobe     <= 1'b1;
                            px.o_data_valid <= (row_r >= ROW_VALID);
                        end else begin
                            px.o_strobe     <= 1'b0;
                            px.o_data_valid <= 1'b0;
                        end
                        if (row_r == ROW_LAST) begin
                            row_r <= '0;
                            if (col_r == COL_LAST) begin
                                col_r        <= '0;
                                px.o_ready   <= 1'b0;
                                o_frame_done <= 1'b1;
                                state_r      <= ST_DONE;
                            end else begin
                                col_r <= col_r + CW'(1);
                            end
                        end else begin
                            row_r <= row_r + RW'(1);
                        end
                    end else begin
                        px.o_strobe     <= 1'b0;
                        px.o_data_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    px.o_strobe     <= 1'b0;
                    px.o_data_valid <= 1'b0;
                    o_frame_done    <= 1'b0;
                    o_busy          <= 1'b0;
                    state_r         <= ST_IDLE;
                end
                default: begin
                    px.o_ready      <= 1'b0;
                    px.o_load_knl   <= 1'b0;
                    px.o_strobe     <= 1'b0;
                    px.o_data_valid <= 1'b0;
                    o_busy          <= 1'b0;
                    o_frame_done    <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/conv_column_feeder.md
Name: conv_column_feeder

Overview:
Upstream stage of conv_2d. It takes a zero-padded frame streamed column-major, one 8-bit pixel per beat, and first emits the 3x3 kernel over three cycles with o_load_knl. It then delivers three adjacent columns per cycle (o_data1/2/3 = columns c-2, c-1, c at the same row) plus o_data_valid, exactly as conv_2d consumes them. Two internal column buffers provide the c-2 and c-1 pixels, so the frame is read once with no external re-reads.

Parameters:
IMAGE_HEIGHT, 12, padded frame height (rows per column), >=3
IMAGE_WIDTH, 3, padded frame width (columns), >=3
DATA_W, 8, pixel and kernel coefficient width (signed)
VALID_ROW_START, 3, first row index in a strip at which o_data_valid asserts (absorbs conv_2d's one-cycle window latency)

Ports:
clk  in  1  clock
i_nrst  in  1  reset, asynchronous, active-low
i_start  in  1  one-cycle pulse in IDLE; latches i_kernel and begins a frame
i_kernel  in  9*DATA_W  coefficients k1..k9; kN occupies bits [N*DATA_W-1 : (N-1)*DATA_W]
i_pixel  in  DATA_W  padded-frame pixel, column-major (row fastest)
i_valid  in  1  i_pixel valid
o_ready  out  1  pixel accepted on the cycle when i_valid && o_ready
o_load_knl  out  1  kernel-load strobe to conv_2d
o_data1  out  DATA_W  column c-2, or kernel triple element 1
o_data2  out  DATA_W  column c-1, or kernel triple element 2
o_data3  out  DATA_W  column c, or kernel triple element 3
o_strobe  out  1  one output beat (triple) presented this cycle
o_data_valid  out  1  beat holds a complete window row for conv_2d
o_busy  out  1  high outside IDLE
o_frame_done  out  1  one-cycle pulse after the last output beat

Behaviour:
- Reset (async, i_nrst=0): state=IDLE. All outputs are 0, including o_data*, o_ready, o_load_knl, o_strobe, o_data_valid, o_busy and o_frame_done. Row and column counters clear. Buffer contents are don't-care. Deassertion takes effect on the next clk edge.
- FSM states: IDLE, KNL0, KNL1, KNL2, STREAM, DONE. All outputs are registered.
- IDLE: o_ready=0. If i_start=1, latch i_kernel and go to KNL0. i_start is ignored outside IDLE.
- KNL0/1/2: one cycle each with o_load_knl=1.
  - KNL0 emits (k9,k8,k7) on o_data1/2/3.
  - KNL1 emits (k6,k5,k4).
  - KNL2 emits (k3,k2,k1).
  - o_strobe=0 and o_ready=0 throughout. KNL2 goes to STREAM.
- STREAM: o_ready=1. On accept, with current counters (row r, col c):
  - Write i_pixel to bufB[r] and move the old bufB[r] to bufA[r].
  - If c>=2, then on the next cycle: o_data1=old bufA[r], o_data2=old bufB[r], o_data3=i_pixel, and o_strobe=1. Latency is 1 cycle from accept to output.
  - o_data_valid = o_strobe && (r >= VALID_ROW_START).
  - r increments, wrapping at IMAGE_HEIGHT-1 to 0 with c incrementing.
  - For columns 0 and 1 (c<2), o_strobe=0 and o_data* hold their previous values.
- No accept in a cycle (i_valid=0): o_strobe=0, o_data_valid=0, o_data* hold. Counters do not move. The downstream must tolerate the gap; the bench keeps the stream continuous within a strip.
- Last pixel accepted (r=IMAGE_HEIGHT-1, c=IMAGE_WIDTH-1): o_ready drops on the next cycle and the state goes to DONE. DONE lasts one cycle with o_frame_done=1, the final beat's strobe/valid present, and o_busy=1. It then returns to IDLE.
- Output beats per frame: (IMAGE_WIDTH-2)*IMAGE_HEIGHT. Valid beats per frame: (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-VALID_ROW_START).
- Arithmetic: no arithmetic on data; pixels pass bit-exact, signed. Counters are sized $clog2 of their dimension.
- Reset mid-frame: abort immediately. Outputs are 0 and the next frame requires i_start again.

Decomposition:
- Shared package conv_pkg: DATA_W, kernel-slice index constants, FSM state encoding (localparams).
- Natural sub-module column_buffer: a depth IMAGE_HEIGHT, two-stage shift-by-column RAM pair with one write port and one read port indexed by row. The top instantiates it once and keeps the FSM and counters.

Test Plan:
- Kernel load: i_kernel with kN=N, pulse i_start -> o_load_knl high exactly 3 cycles with triples (9,8,7), (6,5,4), (3,2,1); o_strobe=0 throughout.
- Default 12x3 frame, pixel(r,c)=16*c+r, continuous i_valid -> no beats during columns 0-1. Then 12 beats with triple (r, 16+r, 32+r) for r=0..11. o_data_valid high for r=3..11 (9 beats). o_frame_done pulses once, then IDLE.
- IMAGE_WIDTH=5, same pattern -> 3 strips of 12 beats. Strip 2 row 4 gives (36, 52, 68). Exactly 36 strobes and 27 valids.
- i_valid gaps: drop i_valid for 2 cycles mid-strip at r=6 -> o_strobe=0 and o_data* held for 2 cycles. The sequence resumes with (6, 22, 38) and no beat lost or duplicated.
- Reset mid-STREAM at c=2, r=5 -> all outputs 0 same cycle. A new i_start reloads the kernel and a fresh frame matches the golden stream.
- Start ignored: i_start pulsed during STREAM -> no effect on beats, counters or kernel.
